// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One product or quotient bit is resolved per clock; signed ops run on magnitudes.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    localparam int CW = $clog2(WIDTH + 1);

    state_t               state, state_next;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;     // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]     b_q;     // multiplicand or divisor magnitude
    logic                 is_div_q, neg_q, rem_neg_q, dbz_q;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    assign busy = (state != IDLE);

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == CW'(1)) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_neg = op[0] & rs_data[WIDTH-1];
        b_neg = op[0] & rt_data[WIDTH-1];
        a_mag = a_neg ? -rs_data : rs_data;
        b_mag = b_neg ? -rt_data : rt_data;

        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        div_diff  = div_shift - {1'b0, b_q};
        div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

        prod_fix = neg_q ? -acc : acc;
        quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= IDLE;
            count       <= '0;
            acc         <= '0;
            b_q         <= '0;
            is_div_q    <= 1'b0;
            neg_q       <= 1'b0;
            rem_neg_q   <= 1'b0;
            dbz_q       <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state       <= state_next;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        dbz_q     <= op[1] & (rt_data == '0);
                        count     <= CW'(WIDTH);
                        // Multiplier and dividend both start in the low half.
                        acc       <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
                        b_q       <= op[1] ? b_mag : a_mag;
                    end else begin
                        if (hi_we) hi <= rs_data;
                        if (lo_we) lo <= rs_data;
                    end
                end
                RUN: begin
                    acc   <= is_div_q ? div_next : mul_next;
                    count <= count - CW'(1);
                end
                FINISH: begin
                    done <= 1'b1;
                    if (!is_div_q) begin
                        {hi, lo} <= prod_fix;
                    end else if (dbz_q) begin
                        div_by_zero <= 1'b1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quot_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
